// File: rtl/i2c_flash_responder.sv
// Two-wire flash bus responder: decodes START/STOP, device address, a 16-bit word
// address and data bytes, and serves a synchronous byte memory through a simple port.
// sda is open-drain: it is either driven low or released.
module i2c_flash_responder #(
  parameter logic [6:0]  DEV_ADDR = 7'b1010000,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned ACK_HOLD = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_scl,
  inout  wire               b_sda,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wr_en,
  output logic [7:0]        o_mem_wdata,
  output logic              o_mem_rd_en,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_busy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDev    = 3'd1;
  localparam logic [2:0] StAhi    = 3'd2;
  localparam logic [2:0] StAlo    = 3'd3;
  localparam logic [2:0] StWdata  = 3'd4;
  localparam logic [2:0] StRdata  = 3'd5;
  localparam logic [2:0] StIgnore = 3'd6;

  // A hold of zero is treated as one cycle so the drive always lags the scl fall.
  localparam logic [7:0]        HoldInit = (ACK_HOLD == 0) ? 8'd1 : 8'(ACK_HOLD);
  localparam logic [ADDR_W-1:0] PtrOne   = {{(ADDR_W-1){1'b0}}, 1'b1};

  // [0],[1] synchronize, [2] holds the previous synchronized value for edge detect.
  logic [2:0] scl_sync_q, sda_sync_q;

  logic [2:0]        state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              ack_phase_q, ack_phase_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic [7:0]        sr_q, sr_d;
  logic [7:0]        ahi_q, ahi_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              rd_dly_q;
  logic              oe_q, oe_d;
  logic              nxt_q, nxt_d;      // sda drive value to apply when the hold expires
  logic [7:0]        hold_q, hold_d;
  logic              msb_wait_q, msb_wait_d; // first read byte still in flight from memory

  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, start_c, stop_c, apply;
  logic [7:0] byte_in;

  assign scl_s    = scl_sync_q[1];
  assign scl_p    = scl_sync_q[2];
  assign sda_s    = sda_sync_q[1];
  assign sda_p    = sda_sync_q[2];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start_c  = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_c   = scl_s & scl_p & ~sda_p & sda_s;
  assign apply    = (hold_q == 8'd1);
  assign byte_in  = {sr_q[6:0], sda_s};

  assign b_sda       = oe_q ? 1'b0 : 1'bz;
  assign o_mem_addr  = addr_q;
  assign o_mem_wr_en = wr_en_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_rd_en = rd_en_q;
  assign o_busy      = busy_q;

  // Bus synchronizers; idle bus is high, so reset to 1 to avoid false edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], i_scl};
      sda_sync_q <= {sda_sync_q[1:0], b_sda};
    end
  end

  // Protocol FSM, pointer, memory strobes and delayed sda drive.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    ack_phase_d = ack_phase_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    sr_d        = sr_q;
    ahi_d       = ahi_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    oe_d        = oe_q;
    nxt_d       = nxt_q;
    hold_d      = hold_q;
    msb_wait_d  = msb_wait_q;

    if (hold_q != 8'd0) hold_d = hold_q - 8'd1;
    if (apply) oe_d = nxt_q;

    // Memory data lands one cycle after the strobe; the pointer advances on capture.
    if (rd_dly_q) begin
      tx_d  = i_mem_rdata;
      ptr_d = ptr_q + PtrOne;
      if (msb_wait_q) begin
        msb_wait_d = 1'b0;
        nxt_d      = ~i_mem_rdata[7];
        // Hold already expired (or expires now): drive the MSB straight away.
        if (hold_q <= 8'd1) oe_d = ~i_mem_rdata[7];
      end
    end

    if (start_c || stop_c) begin
      state_d     = start_c ? StDev : StIdle;
      bit_cnt_d   = 4'd0;
      ack_phase_d = 1'b0;
      oe_d        = 1'b0;
      nxt_d       = 1'b0;
      hold_d      = 8'd0;
      msb_wait_d  = 1'b0;
      if (stop_c) busy_d = 1'b0;
    end else begin
      case (state_q)
        StDev, StAhi, StAlo, StWdata: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            sr_d      = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              case (state_q)
                StDev: begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                    busy_d = 1'b1;
                    rw_d   = byte_in[0];
                  end else begin
                    state_d = StIgnore;
                  end
                end
                StAhi: ahi_d = byte_in;
                StAlo: ptr_d = ADDR_W'({ahi_q, byte_in});
                default: begin
                  wdata_d = byte_in;
                  addr_d  = ptr_q;
                  wr_en_d = 1'b1;
                  ptr_d   = ptr_q + PtrOne;
                end
              endcase
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            hold_d = HoldInit;
            if (!ack_phase_q) begin
              ack_phase_d = 1'b1;
              nxt_d       = 1'b1;
            end else begin
              ack_phase_d = 1'b0;
              bit_cnt_d   = 4'd0;
              nxt_d       = 1'b0;
              case (state_q)
                StDev: begin
                  if (rw_q) begin
                    state_d    = StRdata;
                    rd_en_d    = 1'b1;
                    addr_d     = ptr_q;
                    msb_wait_d = 1'b1;
                  end else begin
                    state_d = StAhi;
                  end
                end
                StAhi:   state_d = StAlo;
                default: state_d = StWdata;
              endcase
            end
          end
        end
        StRdata: begin
          // bit_cnt 9 marks "master ACK seen, next byte prefetched".
          if (scl_rise) begin
            if (bit_cnt_q < 4'd8) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              if (!sda_s) begin
                rd_en_d   = 1'b1;
                addr_d    = ptr_q;
                bit_cnt_d = 4'd9;
              end else begin
                state_d = StIgnore;
              end
            end
          end else if (scl_fall) begin
            if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd7) begin
              tx_d   = {tx_q[6:0], 1'b0};
              nxt_d  = ~tx_q[6];
              hold_d = HoldInit;
            end else if (bit_cnt_q == 4'd8) begin
              nxt_d  = 1'b0;
              hold_d = HoldInit;
            end else if (bit_cnt_q == 4'd9) begin
              bit_cnt_d = 4'd0;
              nxt_d     = ~tx_q[7];
              hold_d    = HoldInit;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; reset releases sda immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      ack_phase_q <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      sr_q        <= 8'd0;
      ahi_q       <= 8'd0;
      tx_q        <= 8'd0;
      ptr_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= 8'd0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_dly_q    <= 1'b0;
      oe_q        <= 1'b0;
      nxt_q       <= 1'b0;
      hold_q      <= 8'd0;
      msb_wait_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ack_phase_q <= ack_phase_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      sr_q        <= sr_d;
      ahi_q       <= ahi_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      rd_dly_q    <= rd_en_q;
      oe_q        <= oe_d;
      nxt_q       <= nxt_d;
      hold_q      <= hold_d;
      msb_wait_q  <= msb_wait_d;
    end
  end

endmodule

// File: tb/tb_i2c_flash_responder.sv
// Directed bench for i2c_flash_responder: bus master tasks plus a byte memory model.
module tb_i2c_flash_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl;
  logic        m_oe;
  wire         sda_w;
  logic [15:0] mem_addr;
  logic        mem_wr_en;
  logic [7:0]  mem_wdata;
  logic        mem_rd_en;
  logic [7:0]  mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  assign sda_w = m_oe ? 1'b0 : 1'bz;
  pullup (sda_w);

  i2c_flash_responder dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_scl       (scl),
    .b_sda       (sda_w),
    .o_mem_addr  (mem_addr),
    .o_mem_wr_en (mem_wr_en),
    .o_mem_wdata (mem_wdata),
    .o_mem_rd_en (mem_rd_en),
    .i_mem_rdata (mem_rdata),
    .o_busy      (busy)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [15:0] rd_addr_q[$];
  bit          both_seen = 1'b0;

  // Memory model and strobe logger.
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      rd_addr_q.push_back(mem_addr);
    end
    if (mem_wr_en && mem_rd_en) both_seen <= 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_oe = 1'b0; cyc(8);
    scl  = 1'b1; cyc(8);
    m_oe = 1'b1; cyc(8);
    scl  = 1'b0; cyc(2);
  endtask

  task automatic bus_stop();
    m_oe = 1'b1; cyc(6);
    scl  = 1'b1; cyc(8);
    m_oe = 1'b0; cyc(8);
  endtask

  task automatic send_bit(input logic b);
    m_oe = ~b; cyc(6);
    scl  = 1'b1; cyc(8);
    scl  = 1'b0; cyc(2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_oe = 1'b0; cyc(6);
    scl  = 1'b1; cyc(4);
    ack  = sda_w; cyc(4);
    scl  = 1'b0; cyc(2);
  endtask

  task automatic recv_byte(input logic give_ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      m_oe = 1'b0; cyc(6);
      scl  = 1'b1; cyc(4);
      d[i] = sda_w; cyc(4);
      scl  = 1'b0; cyc(2);
    end
    m_oe = give_ack; cyc(6);
    scl  = 1'b1; cyc(8);
    scl  = 1'b0; cyc(2);
    m_oe = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; m_oe = 1'b0;
    cyc(3); rst_n = 1'b1; cyc(4);
    tests++; if (sda_w !== 1'b1) begin fails++; $display("FAIL reset_sda got %b want 1", sda_w); end
    tests++; if (mem_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", mem_wr_en); end
    tests++; if (mem_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
    tests++; if (mem_addr !== 16'h0) begin fails++; $display("FAIL reset_addr got %h want 0000", mem_addr); end
    tests++; if (mem_wdata !== 8'h0) begin fails++; $display("FAIL reset_wdata got %h want 00", mem_wdata); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_byte_write();
    logic a0, a1, a2, a3, a4;
    int w0, r0;
    w0 = wr_addr_q.size(); r0 = rd_addr_q.size();
    bus_start();
    send_byte(8'hA0, a0); send_byte(8'h00, a1); send_byte(8'h10, a2);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL write_busy got %b want 1", busy); end
    send_byte(8'h5A, a3); send_byte(8'h3C, a4);
    bus_stop();
    tests++; if ({a0, a1, a2, a3, a4} !== 5'b0) begin
      fails++; $display("FAIL write_acks got %b want 00000", {a0, a1, a2, a3, a4}); end
    tests++; if (wr_addr_q.size() - w0 != 2) begin
      fails++; $display("FAIL write_count got %0d want 2", wr_addr_q.size() - w0); end
    else begin
      tests++; if (wr_addr_q[w0] !== 16'h0010 || wr_data_q[w0] !== 8'h5A) begin
        fails++; $display("FAIL write_0 got %h/%h want 0010/5a", wr_addr_q[w0], wr_data_q[w0]); end
      tests++; if (wr_addr_q[w0+1] !== 16'h0011 || wr_data_q[w0+1] !== 8'h3C) begin
        fails++; $display("FAIL write_1 got %h/%h want 0011/3c", wr_addr_q[w0+1], wr_data_q[w0+1]); end
    end
    tests++; if (rd_addr_q.size() != r0) begin
      fails++; $display("FAIL write_no_read got %0d want 0", rd_addr_q.size() - r0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL write_busy_stop got %b want 0", busy); end
  endtask

  task automatic test_random_read();
    logic a0, a1, a2, a3;
    logic [7:0] d0, d1, d2;
    int r0;
    r0 = rd_addr_q.size();
    bus_start();
    send_byte(8'hA0, a0); send_byte(8'h00, a1); send_byte(8'h10, a2);
    bus_start();
    send_byte(8'hA1, a3);
    recv_byte(1'b1, d0);
    recv_byte(1'b0, d1);
    tests++; if (sda_w !== 1'b1) begin fails++; $display("FAIL read_nack_release got %b want 1", sda_w); end
    bus_stop();
    tests++; if ({a0, a1, a2, a3} !== 4'b0) begin
      fails++; $display("FAIL read_acks got %b want 0000", {a0, a1, a2, a3}); end
    tests++; if (d0 !== 8'h5A) begin fails++; $display("FAIL read_d0 got %h want 5a", d0); end
    tests++; if (d1 !== 8'h3C) begin fails++; $display("FAIL read_d1 got %h want 3c", d1); end
    tests++; if (rd_addr_q.size() - r0 != 2) begin
      fails++; $display("FAIL read_strobes got %0d want 2", rd_addr_q.size() - r0); end
    else begin
      tests++; if (rd_addr_q[r0] !== 16'h0010 || rd_addr_q[r0+1] !== 16'h0011) begin
        fails++; $display("FAIL read_addrs got %h,%h want 0010,0011", rd_addr_q[r0], rd_addr_q[r0+1]); end
    end
    // Current-address read exposes the retained pointer.
    r0 = rd_addr_q.size();
    bus_start(); send_byte(8'hA1, a0); recv_byte(1'b0, d2); bus_stop();
    tests++; if (rd_addr_q.size() == r0 || rd_addr_q[r0] !== 16'h0012) begin
      fails++; $display("FAIL read_ptr got %h want 0012",
                        (rd_addr_q.size() > r0) ? rd_addr_q[r0] : 16'hxxxx); end
  endtask

  task automatic test_wrap();
    logic a;
    logic [7:0] d;
    int w0, r0;
    w0 = wr_addr_q.size();
    bus_start();
    send_byte(8'hA0, a); send_byte(8'hFF, a); send_byte(8'hFF, a);
    send_byte(8'h11, a); send_byte(8'h22, a);
    bus_stop();
    tests++; if (wr_addr_q.size() - w0 != 2) begin
      fails++; $display("FAIL wrap_count got %0d want 2", wr_addr_q.size() - w0); end
    else begin
      tests++; if (wr_addr_q[w0] !== 16'hFFFF || wr_data_q[w0] !== 8'h11) begin
        fails++; $display("FAIL wrap_0 got %h/%h want ffff/11", wr_addr_q[w0], wr_data_q[w0]); end
      tests++; if (wr_addr_q[w0+1] !== 16'h0000 || wr_data_q[w0+1] !== 8'h22) begin
        fails++; $display("FAIL wrap_1 got %h/%h want 0000/22", wr_addr_q[w0+1], wr_data_q[w0+1]); end
    end
    r0 = rd_addr_q.size();
    bus_start(); send_byte(8'hA1, a); recv_byte(1'b0, d); bus_stop();
    tests++; if (rd_addr_q.size() == r0 || rd_addr_q[r0] !== 16'h0001) begin
      fails++; $display("FAIL wrap_ptr got %h want 0001",
                        (rd_addr_q.size() > r0) ? rd_addr_q[r0] : 16'hxxxx); end
  endtask

  task automatic test_wrong_addr();
    logic a;
    int w0, r0;
    w0 = wr_addr_q.size(); r0 = rd_addr_q.size();
    bus_start();
    send_byte(8'hA2, a);
    tests++; if (a !== 1'b1) begin fails++; $display("FAIL wrong_nack got %b want 1", a); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wrong_busy got %b want 0", busy); end
    send_byte(8'h00, a);
    bus_stop();
    tests++; if (wr_addr_q.size() != w0 || rd_addr_q.size() != r0) begin
      fails++; $display("FAIL wrong_strobes got %0d want 0",
                        wr_addr_q.size() - w0 + rd_addr_q.size() - r0); end
    bus_start(); send_byte(8'hA0, a); bus_stop();
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL wrong_then_valid got %b want 0", a); end
  endtask

  task automatic test_abort();
    logic a;
    int w0;
    bus_start();
    send_byte(8'hA0, a); send_byte(8'h00, a); send_byte(8'h20, a);
    w0 = wr_addr_q.size();
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    bus_stop();
    tests++; if (wr_addr_q.size() != w0) begin
      fails++; $display("FAIL abort_no_write got %0d want 0", wr_addr_q.size() - w0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    bus_start(); send_byte(8'hA0, a); bus_stop();
    tests++; if (a !== 1'b0) begin fails++; $display("FAIL abort_next_ack got %b want 0", a); end
  endtask

  task automatic test_reset_mid_read();
    logic a;
    logic [7:0] d;
    int r0;
    bus_start();
    send_byte(8'hA0, a); send_byte(8'h00, a); send_byte(8'h40, a); send_byte(8'h0F, a);
    bus_stop();
    bus_start();
    send_byte(8'hA0, a); send_byte(8'h00, a); send_byte(8'h40, a);
    bus_start();
    send_byte(8'hA1, a);
    cyc(6);
    tests++; if (sda_w !== 1'b0) begin fails++; $display("FAIL rst_read_msb got %b want 0", sda_w); end
    rst_n = 1'b0;
    #1;
    tests++; if (sda_w !== 1'b1) begin fails++; $display("FAIL rst_sda_release got %b want 1", sda_w); end
    tests++; if (busy !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 8'h0 ||
                 mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
      fails++; $display("FAIL rst_outputs got busy=%b addr=%h wdata=%h wr=%b rd=%b want all 0",
                        busy, mem_addr, mem_wdata, mem_wr_en, mem_rd_en); end
    cyc(3); rst_n = 1'b1; cyc(4);
    r0 = rd_addr_q.size();
    bus_start(); send_byte(8'hA1, a); recv_byte(1'b0, d); bus_stop();
    tests++; if (rd_addr_q.size() == r0 || rd_addr_q[r0] !== 16'h0000) begin
      fails++; $display("FAIL rst_ptr got %h want 0000",
                        (rd_addr_q.size() > r0) ? rd_addr_q[r0] : 16'hxxxx); end
  endtask

  task automatic test_strobe_exclusive();
    tests++; if (both_seen !== 1'b0) begin
      fails++; $display("FAIL strobe_exclusive got %b want 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_random_read();
    test_wrap();
    test_wrong_addr();
    test_abort();
    test_reset_mid_read();
    test_strobe_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
